// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL field positions, mode codes, FSM encoding and the bridge address windows.
package timer_counter_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;
    localparam logic [1:0] ADDR_UNUSED = 2'b11;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Byte-address windows decoded upstream; each spans three words.
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC0_LAST = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC1_LAST = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer peripheral: CTRL/PRESET/COUNT registers, a four-state
// sequencing FSM and an interrupt request gated by the CTRL mask bit.
//
// state | meaning
// IDLE  | waiting for EN
// LOAD  | COUNT <= PRESET
// CNT   | decrementing toward 1, then raise irq_flag
// INT   | one-shot clears EN; auto-reload clears irq_flag
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    tc_state_e         state_q, state_d;

    logic wr_ctrl, wr_preset, bus_wr;
    logic en, auto_reload;
    logic load_cnt, dec_cnt, zero_cnt, set_flag, clr_flag, clr_en;

    assign wr_ctrl     = we && (addr == ADDR_CTRL);
    assign wr_preset   = we && (addr == ADDR_PRESET);
    assign bus_wr      = wr_ctrl || wr_preset;
    assign en          = ctrl_q[CTRL_EN_BIT];
    assign auto_reload = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A CTRL/PRESET write restarts the sequence from IDLE.
    always_comb begin
        state_d = state_q;
        if (bus_wr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (en) state_d = ST_LOAD;
                ST_LOAD: state_d = ST_CNT;
                ST_CNT: begin
                    if (!en)                 state_d = ST_IDLE;
                    else if (count_q <= 32'd1) state_d = ST_INT;
                end
                ST_INT:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM actions are suppressed on a bus write so COUNT freezes when EN is cleared.
    always_comb begin
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        zero_cnt = 1'b0;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        clr_en   = 1'b0;
        if (!bus_wr) begin
            case (state_q)
                ST_LOAD: load_cnt = 1'b1;
                ST_CNT: begin
                    if (en) begin
                        if (count_q > 32'd1) begin
                            dec_cnt = 1'b1;
                        end else begin
                            zero_cnt = 1'b1;
                            set_flag = 1'b1;
                        end
                    end
                end
                ST_INT: begin
                    if (auto_reload) clr_flag = 1'b1;
                    else             clr_en   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (wr_ctrl)     ctrl_d = wdata[CTRL_W-1:0];
        else if (clr_en) ctrl_d[CTRL_EN_BIT] = 1'b0;

        if (wr_preset) preset_d = wdata;

        if (load_cnt)      count_d = preset_q;
        else if (dec_cnt)  count_d = count_q - 32'd1;
        else if (zero_cnt) count_d = 32'd0;

        if (bus_wr)        irq_flag_d = 1'b0;
        else if (set_flag) irq_flag_d = 1'b1;
        else if (clr_flag) irq_flag_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            ADDR_UNUSED: rdata = 32'd0;
            default:     rdata = 32'd0;
        endcase
    end

    assign irq = ctrl_q[CTRL_IM_BIT] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one-shot, auto-reload, masking, stop,
// async reset and register-map edge cases against hand-computed values.
module tb_timer_counter;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_UNUSED = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    // Called just after a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        tick(2);
        check_reg("rst_ctrl",   A_CTRL,   32'd0);
        check_reg("rst_preset", A_PRESET, 32'd0);
        check_reg("rst_count",  A_COUNT,  32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;

        // One-shot, N = 5, IM = 1
        wr(A_PRESET, 32'd5);
        check_reg("os_preset", A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        tick(1);
        check("os_irq_e1", {31'd0, irq}, 32'd0);
        tick(1);
        check_reg("os_count_e2", A_COUNT, 32'd5);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check_reg($sformatf("os_count_e%0d", k + 2), A_COUNT, 32'd5 - 32'(k));
        end
        check("os_irq_e6", {31'd0, irq}, 32'd0);
        tick(1);
        check_reg("os_count_e7", A_COUNT, 32'd0);
        check("os_irq_e7", {31'd0, irq}, 32'd1);
        tick(1);
        check_reg("os_ctrl_en_clr", A_CTRL, 32'h8);
        check("os_irq_e8", {31'd0, irq}, 32'd1);
        tick(5);
        check("os_irq_hold", {31'd0, irq}, 32'd1);
        wr(A_PRESET, 32'd5);
        check("os_irq_cleared", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h9);
        tick(7);
        check("os_rearm_irq", {31'd0, irq}, 32'd1);

        // Asynchronous reset between edges with irq pending
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_irq", {31'd0, irq}, 32'd0);
        check_reg("areset_ctrl",   A_CTRL,   32'd0);
        check_reg("areset_preset", A_PRESET, 32'd0);
        check_reg("areset_count",  A_COUNT,  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Auto-reload, N = 5: irq at E7, E15, E23
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            check($sformatf("ar_irq_e%0d", k), {31'd0, irq},
                  (k >= 7 && ((k - 7) % 8) == 0) ? 32'd1 : 32'd0);
            if ((k % 8) == 2)
                check_reg($sformatf("ar_reload_e%0d", k), A_COUNT, 32'd5);
        end
        pulse_reset();

        // Masked one-shot, N = 2
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check($sformatf("mask_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        check_reg("mask_count", A_COUNT, 32'd0);
        check_reg("mask_ctrl",  A_CTRL,  32'd0);
        pulse_reset();

        // Stop mid-count at COUNT = 60
        wr(A_PRESET, 32'd100);
        wr(A_CTRL, 32'h9);
        tick(42);
        check_reg("stop_count_before", A_COUNT, 32'd60);
        wr(A_CTRL, 32'h0);
        check_reg("stop_count_edge", A_COUNT, 32'd60);
        tick(5);
        check_reg("stop_count_hold", A_COUNT, 32'd60);
        check("stop_irq", {31'd0, irq}, 32'd0);

        wr(A_COUNT, 32'h0000_ABCD);
        check_reg("count_wr_ignored", A_COUNT, 32'd60);
        check_reg("preset_intact", A_PRESET, 32'd100);
        wr(A_UNUSED, 32'hFFFF_FFFF);
        check_reg("unused_reads0", A_UNUSED, 32'd0);

        // PRESET = 0 behaves as 1
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h9);
        tick(2);
        check("p0_irq_e2", {31'd0, irq}, 32'd0);
        tick(1);
        check("p0_irq_e3", {31'd0, irq}, 32'd1);
        check_reg("p0_count", A_COUNT, 32'd0);

        wr(A_CTRL, 32'hFFFF_FFFF);
        check_reg("ctrl_width", A_CTRL, 32'hF);
        check("ctrl_wr_clears_irq", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
